radial_zone_sequencer_fp16: RTL and testbench
=============================================

# radial_zone_sequencer_fp16

Raster-scan sequencer for the radial per-zone coefficient lookup in the dfdd datapath. On each frame start it walks every pixel coordinate of a W×H frame and drives the coordinates through the `radial_a_b_fp16` zone lookup. It streams out the selected fp16 `a`/`b` coefficients with their coordinates over a valid/ready interface. It also owns the zone configuration registers, as a shadow bank plus an active bank that swap only at frame start.

## Interface
- `NO_ZONES`, 4: number of radial zones; must be ≥ 1.
- `ZW`, `$clog2(NO_ZONES)` (min 1): zone index width.

- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: frame start request; sampled only in IDLE.
- `frame_width_i` in 16: W, unsigned; sampled on accepted start.
- `frame_height_i` in 16: H, unsigned; sampled on accepted start.
- `col_center_i` in 16: radial center column; sampled on accepted start.
- `row_center_i` in 16: radial center row; sampled on accepted start.
- `cfg_we_i` in 1: shadow-bank write strobe.
- `cfg_zone_i` in ZW: zone index to write.
- `cfg_a_i` in 16: fp16 a coefficient for the zone.
- `cfg_b_i` in 16: fp16 b coefficient for the zone.
- `cfg_r_squared_i` in 16: zone threshold.
- `busy_o` out 1: high in RUN/DRAIN.
- `done_o` out 1: one-cycle pulse at frame end.
- `valid_o` out 1: output beat valid.
- `ready_i` in 1: downstream accepts the beat.
- `col_o` out 16: beat column.
- `row_o` out 16: beat row.
- `a_o` out 16: selected a coefficient.
- `b_o` out 16: selected b coefficient.
- `last_o` out 1: final pixel of the frame.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- **IDLE**
  - If `start_i` and W≠0 and H≠0: copy shadow to active bank, latch W/H/centers, zero col/row counters, go to RUN.
  - If `start_i` and W=0 or H=0: pulse `done_o` next cycle, emit no beats, stay in IDLE.
- **RUN**
  - Each cycle with `en`, issue (col,row) into stage S1.
  - col increments; at col=W−1 it wraps to 0 and row increments.
  - Issuing (W−1,H−1) tags the entry last and moves to DRAIN.
- **DRAIN**
  - Issue nothing; v1 clears on `en`.
  - When `valid_o && ready_i && last_o`, go to IDLE and pulse `done_o` in the next cycle.
- `start_i` in RUN/DRAIN is ignored.
- **Zone lookup** (combinational on S1 output, via `radial_a_b_fp16`):
  - dc = col−col_center and dr = row−row_center, signed 16-bit, wrap on overflow.
  - d² = dc²+dr², each term and the sum truncated to 16 bits; compare unsigned.
  - Default selection is zone NO_ZONES−1.
  - For z=0..NO_ZONES−2 ascending, d² ≥ r_sq[z] selects zone z; the highest matching z wins.
- **Config writes**
  - `cfg_we_i` writes shadow[cfg_zone_i] in any state.
  - cfg_zone_i ≥ NO_ZONES: the write is dropped.
  - A write in the same cycle as an accepted start is not visible to that frame; the copy uses pre-write shadow contents.
  - The active bank never changes mid-frame.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: `valid_o`, `done_o`, `busy_o`, `last_o`, `col_o`, `row_o`, `a_o`, `b_o`.
  - v1 = 0; shadow and active banks all zero.
- Reset mid-frame: the next cycle shows reset values; the frame is abandoned with no `done_o`.
- Pipeline: S1 (registered coords + v1 + last) → S2 (output registers, `valid_o`).
- Global advance `en = !valid_o || ready_i`. When `en` is low, counters, S1 and S2 all hold.
- Outputs are stable while `valid_o && !ready_i`.
- Start sampled in cycle T:
  - `busy_o` high from T+1.
  - The (0,0) beat has `valid_o` in T+3.
  - With `ready_i` held high, throughput is 1 beat/cycle and the last beat appears in T+W·H+2.
  - `done_o` is high in T+W·H+3, with `busy_o` low in the same cycle.
- A new start is accepted in the `done_o` cycle at the earliest.

## Structure
- Package `dfdd_pkg`: FSM state enum, zone-config struct {a, b, r_squared}, fp16 width constant.
- Sub-module: `radial_a_b_fp16`, one instance between S1 and S2, fed from the active bank.
- Remaining logic sits in this module: counters, FSM, banks, pipeline.

## Test plan
- **Basic frame**
  - NO_ZONES=3; r_sq={1,4,x}; a={0x3C00,0x4000,0x4200}; W=4, H=2, center (1,0); `ready_i`=1.
  - 8 beats in raster order.
  - (0,0): a=0x3C00. (1,0): a=0x4200. (3,0): a=0x4000.
  - `last_o` only on (3,1); `done_o` 1 cycle later.
- **Backpressure**
  - Same frame; `ready_i` toggles 1,0,0,1 repeating.
  - No beat lost or duplicated; outputs held stable while stalled.
  - Order identical to the no-backpressure run.
- **Shadow isolation**
  - Rewrite zone 0 a=0x5000 mid-frame → current frame unchanged.
  - The next frame uses 0x5000.
  - A write coincident with start → not used until the following start.
- **Zero-size frame**
  - W=0, H=5 start → no `valid_o`; `done_o` pulses next cycle; `busy_o` stays 0.
- **Reset mid-frame**
  - `rst_i` for 1 cycle at beat 3 → next cycle all outputs 0, banks zero, no `done_o`.
  - A new start then runs a full frame from (0,0).
- **Wrap arithmetic**
  - Center (0x8000,0); pixel at col 0 → dc wraps; a_o/b_o match the 16-bit-truncated d² compare.
  - Out-of-range `cfg_zone_i` write is ignored.

Source files
------------

// File: rtl/dfdd_pkg.sv
// Shared types for the dfdd radial coefficient path: sequencer FSM states and per-zone config.
// Pure declarations; no logic, latency or flow control of its own.
package dfdd_pkg;

    localparam int FP16_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [FP16_W-1:0] a;
        logic [FP16_W-1:0] b;
        logic [FP16_W-1:0] r_squared;
    } zone_cfg_t;

endpackage

// File: rtl/radial_a_b_fp16.sv
// Radial zone lookup: picks the fp16 a/b pair whose squared-distance threshold the pixel meets.
// Purely combinational (zero latency); no flow control, the caller registers the result.
module radial_a_b_fp16 import dfdd_pkg::*; #(
    parameter int NO_ZONES = 4
) (
    input  logic [15:0]               col,
    input  logic [15:0]               row,
    input  logic [15:0]               col_center,
    input  logic [15:0]               row_center,
    input  zone_cfg_t [NO_ZONES-1:0]  zone_cfg,
    output logic [FP16_W-1:0]         a,
    output logic [FP16_W-1:0]         b
);

    logic [15:0] dc;
    logic [15:0] dr;
    logic [15:0] dc_sq;
    logic [15:0] dr_sq;
    logic [15:0] d_sq;

    // Only the low 16 bits of each square matter, so the sign of dc/dr can be ignored.
    always_comb begin
        dc    = col - col_center;
        dr    = row - row_center;
        dc_sq = dc * dc;
        dr_sq = dr * dr;
        d_sq  = dc_sq + dr_sq;
        a     = zone_cfg[NO_ZONES-1].a;
        b     = zone_cfg[NO_ZONES-1].b;
        for (int z = 0; z < NO_ZONES - 1; z++) begin
            if (d_sq >= zone_cfg[z].r_squared) begin
                a = zone_cfg[z].a;
                b = zone_cfg[z].b;
            end
        end
    end

endmodule

// File: rtl/radial_zone_sequencer_fp16.sv
// Raster-scan sequencer streaming per-pixel radial zone a/b coefficients; first beat 3 cycles after start.
// valid/ready output; when valid is held without ready the counters, S1 and S2 all freeze.
module radial_zone_sequencer_fp16 import dfdd_pkg::*; #(
    parameter int NO_ZONES = 4,
    parameter int ZW       = (NO_ZONES > 1) ? $clog2(NO_ZONES) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [15:0]       frame_width_i,
    input  logic [15:0]       frame_height_i,
    input  logic [15:0]       col_center_i,
    input  logic [15:0]       row_center_i,
    input  logic              cfg_we_i,
    input  logic [ZW-1:0]     cfg_zone_i,
    input  logic [15:0]       cfg_a_i,
    input  logic [15:0]       cfg_b_i,
    input  logic [15:0]       cfg_r_squared_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [15:0]       col_o,
    output logic [15:0]       row_o,
    output logic [15:0]       a_o,
    output logic [15:0]       b_o,
    output logic              last_o
);

    localparam logic [ZW:0] ZONE_LIMIT = (ZW+1)'(NO_ZONES);

    seq_state_t state;
    seq_state_t state_nxt;

    zone_cfg_t [NO_ZONES-1:0] shadow;
    zone_cfg_t [NO_ZONES-1:0] active;

    logic [15:0] width;
    logic [15:0] height;
    logic [15:0] col_center;
    logic [15:0] row_center;
    logic [15:0] col_cnt;
    logic [15:0] row_cnt;

    logic        v1;
    logic        s1_last;
    logic [15:0] s1_col;
    logic [15:0] s1_row;

    logic        en;
    logic        issue;
    logic        issue_last;
    logic        start_ok;
    logic        done_nxt;

    logic [FP16_W-1:0] lut_a;
    logic [FP16_W-1:0] lut_b;

    assign en     = !valid_o || ready_i;
    assign busy_o = (state != ST_IDLE);

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_last = 1'b0;
        start_ok   = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (frame_width_i != 16'd0 && frame_height_i != 16'd0) begin
                        start_ok  = 1'b1;
                        state_nxt = ST_RUN;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (en) begin
                    issue = 1'b1;
                    if (col_cnt == width - 16'd1 && row_cnt == height - 16'd1) begin
                        issue_last = 1'b1;
                        state_nxt  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (valid_o && ready_i && last_o) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            done_o     <= 1'b0;
            width      <= '0;
            height     <= '0;
            col_center <= '0;
            row_center <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
        end else begin
            state  <= state_nxt;
            done_o <= done_nxt;
            if (start_ok) begin
                width      <= frame_width_i;
                height     <= frame_height_i;
                col_center <= col_center_i;
                row_center <= row_center_i;
                col_cnt    <= '0;
                row_cnt    <= '0;
            end else if (issue) begin
                if (col_cnt == width - 16'd1) begin
                    col_cnt <= '0;
                    row_cnt <= row_cnt + 16'd1;
                end else begin
                    col_cnt <= col_cnt + 16'd1;
                end
            end
        end
    end

    // The copy reads shadow before this cycle's write lands, so a coincident write waits a frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (cfg_we_i && ({1'b0, cfg_zone_i} < ZONE_LIMIT)) begin
                shadow[cfg_zone_i] <= '{a: cfg_a_i, b: cfg_b_i, r_squared: cfg_r_squared_i};
            end
            if (start_ok) begin
                active <= shadow;
            end
        end
    end

    radial_a_b_fp16 #(
        .NO_ZONES (NO_ZONES)
    ) u_lookup (
        .col        (s1_col),
        .row        (s1_row),
        .col_center (col_center),
        .row_center (row_center),
        .zone_cfg   (active),
        .a          (lut_a),
        .b          (lut_b)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1      <= 1'b0;
            s1_last <= 1'b0;
            s1_col  <= '0;
            s1_row  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            col_o   <= '0;
            row_o   <= '0;
            a_o     <= '0;
            b_o     <= '0;
        end else if (en) begin
            v1      <= issue;
            s1_last <= issue_last;
            s1_col  <= col_cnt;
            s1_row  <= row_cnt;
            valid_o <= v1;
            last_o  <= v1 && s1_last;
            col_o   <= s1_col;
            row_o   <= s1_row;
            a_o     <= lut_a;
            b_o     <= lut_b;
        end
    end

endmodule

// File: tb/tb_radial_zone_sequencer_fp16.sv
// Directed bench for radial_zone_sequencer_fp16 with NO_ZONES=3: expected beat tables per frame,
// plus hand sequences for backpressure, shadow isolation, zero-size frames, reset and wrap.
module tb_radial_zone_sequencer_fp16;

    localparam int NZ = 3;
    localparam int ZW = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [15:0]   frame_width_i;
    logic [15:0]   frame_height_i;
    logic [15:0]   col_center_i;
    logic [15:0]   row_center_i;
    logic          cfg_we_i;
    logic [ZW-1:0] cfg_zone_i;
    logic [15:0]   cfg_a_i;
    logic [15:0]   cfg_b_i;
    logic [15:0]   cfg_r_squared_i;
    logic          busy_o;
    logic          done_o;
    logic          valid_o;
    logic          ready_i;
    logic [15:0]   col_o;
    logic [15:0]   row_o;
    logic [15:0]   a_o;
    logic [15:0]   b_o;
    logic          last_o;

    always #5 clk_i = ~clk_i;

    radial_zone_sequencer_fp16 #(
        .NO_ZONES (NZ),
        .ZW       (ZW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .frame_width_i   (frame_width_i),
        .frame_height_i  (frame_height_i),
        .col_center_i    (col_center_i),
        .row_center_i    (row_center_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_zone_i      (cfg_zone_i),
        .cfg_a_i         (cfg_a_i),
        .cfg_b_i         (cfg_b_i),
        .cfg_r_squared_i (cfg_r_squared_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .col_o           (col_o),
        .row_o           (row_o),
        .a_o             (a_o),
        .b_o             (b_o),
        .last_o          (last_o)
    );

    typedef struct {
        logic [15:0] col;
        logic [15:0] row;
        logic [15:0] a;
        logic [15:0] b;
        logic        last;
    } beat_t;

    beat_t expv [0:7];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cfg_wr(input logic [ZW-1:0] z, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] r);
        cfg_we_i        = 1'b1;
        cfg_zone_i      = z;
        cfg_a_i         = a;
        cfg_b_i         = b;
        cfg_r_squared_i = r;
        @(negedge clk_i);
        cfg_we_i        = 1'b0;
    endtask

    // 4x2 frame, center (1,0), r_sq {1,4}: d2=0 -> zone2, 1..3 -> zone0, >=4 -> zone1.
    task automatic load_basic(input logic [15:0] a0);
        expv[0] = '{16'd0, 16'd0, a0,       16'h1111, 1'b0};
        expv[1] = '{16'd1, 16'd0, 16'h4200, 16'h3333, 1'b0};
        expv[2] = '{16'd2, 16'd0, a0,       16'h1111, 1'b0};
        expv[3] = '{16'd3, 16'd0, 16'h4000, 16'h2222, 1'b0};
        expv[4] = '{16'd0, 16'd1, a0,       16'h1111, 1'b0};
        expv[5] = '{16'd1, 16'd1, a0,       16'h1111, 1'b0};
        expv[6] = '{16'd2, 16'd1, a0,       16'h1111, 1'b0};
        expv[7] = '{16'd3, 16'd1, 16'h4000, 16'h2222, 1'b1};
    endtask

    task automatic frame(input logic [15:0] fw, input logic [15:0] fh, input logic [15:0] cc,
                         input logic [15:0] rc, input int nbeats, input bit bp, input int mid_wr,
                         input bit co_wr, input logic [15:0] wr_a);
        int          cyc;
        int          got;
        int          ph;
        int          first_cyc;
        int          last_cyc;
        int          done_cyc;
        bit          stall;
        bit          wrote;
        logic [79:0] held;
        logic [79:0] cur;
        cyc = 0; got = 0; ph = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
        stall = 1'b0; wrote = 1'b0; held = '0;
        start_i        = 1'b1;
        frame_width_i  = fw;
        frame_height_i = fh;
        col_center_i   = cc;
        row_center_i   = rc;
        ready_i        = 1'b1;
        if (co_wr) begin
            cfg_we_i = 1'b1; cfg_zone_i = 2'd0; cfg_a_i = wr_a;
            cfg_b_i = 16'h1111; cfg_r_squared_i = 16'd1;
        end
        @(negedge clk_i);
        cyc = 1; start_i = 1'b0; cfg_we_i = 1'b0;
        while (done_cyc < 0 && cyc < 300) begin
            cur = {14'd0, valid_o, col_o, row_o, a_o, b_o, last_o};
            if (stall) chk("hold_while_stalled", cur, held);
            if (cyc == 1) chk("busy_rise", 80'(busy_o), 80'(1));
            if (done_o) begin
                done_cyc = cyc;
                chk("busy_at_done", 80'(busy_o), 80'(0));
            end
            if (valid_o && first_cyc < 0) first_cyc = cyc;
            ready_i = bp ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
            ph++;
            cfg_we_i = 1'b0;
            if (got == mid_wr && !wrote) begin
                cfg_we_i = 1'b1; cfg_zone_i = 2'd0; cfg_a_i = wr_a;
                cfg_b_i = 16'h1111; cfg_r_squared_i = 16'd1;
                wrote = 1'b1;
            end
            if (valid_o && ready_i) begin
                if (got < nbeats)
                    chk($sformatf("beat%0d", got), 80'({col_o, row_o, a_o, b_o, last_o}),
                        80'({expv[got].col, expv[got].row, expv[got].a, expv[got].b, expv[got].last}));
                else
                    chk("extra_beat", 80'(got), 80'(nbeats));
                if (last_o) last_cyc = cyc;
                got++;
            end
            stall = valid_o && !ready_i;
            held  = cur;
            @(negedge clk_i);
            cyc++;
        end
        cfg_we_i = 1'b0;
        ready_i  = 1'b1;
        chk("beat_count", 80'(got), 80'(nbeats));
        chk("done_seen", 80'(done_cyc >= 0), 80'(1));
        chk("done_after_last", 80'(done_cyc), 80'(last_cyc + 1));
        chk("done_single_cycle", 80'(done_o), 80'(0));
        if (!bp) begin
            chk("first_beat_latency", 80'(first_cyc), 80'(3));
            chk("last_beat_latency", 80'(last_cyc), 80'(nbeats + 2));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        rst_i = 1'b1; start_i = 1'b0; ready_i = 1'b1; cfg_we_i = 1'b0; cfg_zone_i = '0;
        cfg_a_i = '0; cfg_b_i = '0; cfg_r_squared_i = '0;
        frame_width_i = '0; frame_height_i = '0; col_center_i = '0; row_center_i = '0;
        repeat (3) @(negedge clk_i);
        chk("reset_outputs", 80'({valid_o, done_o, busy_o, last_o, col_o, row_o, a_o, b_o}), 80'(0));
        rst_i = 1'b0;

        cfg_wr(2'd0, 16'h3C00, 16'h1111, 16'd1);
        cfg_wr(2'd1, 16'h4000, 16'h2222, 16'd4);
        cfg_wr(2'd2, 16'h4200, 16'h3333, 16'h7777);

        load_basic(16'h3C00);
        frame(16'd4, 16'd2, 16'd1, 16'd0, 8, 1'b0, -1, 1'b0, 16'h0000);
        frame(16'd4, 16'd2, 16'd1, 16'd0, 8, 1'b1, -1, 1'b0, 16'h0000);

        // Shadow isolation: mid-frame write, then a write coincident with start.
        frame(16'd4, 16'd2, 16'd1, 16'd0, 8, 1'b0, 3, 1'b0, 16'h5000);
        load_basic(16'h5000);
        frame(16'd4, 16'd2, 16'd1, 16'd0, 8, 1'b0, -1, 1'b1, 16'h6000);
        load_basic(16'h6000);
        frame(16'd4, 16'd2, 16'd1, 16'd0, 8, 1'b0, -1, 1'b0, 16'h0000);

        start_i = 1'b1; frame_width_i = 16'd0; frame_height_i = 16'd5;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("zero_done", 80'(done_o), 80'(1));
        chk("zero_busy", 80'(busy_o), 80'(0));
        chk("zero_valid", 80'(valid_o), 80'(0));
        @(negedge clk_i);
        chk("zero_done_clear", 80'(done_o), 80'(0));
        repeat (4) begin
            @(negedge clk_i);
            chk("zero_no_beats", 80'({valid_o, busy_o}), 80'(0));
        end

        start_i = 1'b1; frame_width_i = 16'd4; frame_height_i = 16'd2;
        col_center_i = 16'd1; row_center_i = 16'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (valid_o && col_o == 16'd3 && row_o == 16'd0) found = 1'b1;
            else @(negedge clk_i);
        end
        chk("reset_beat3_reached", 80'(found), 80'(1));
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midframe_reset_outputs",
            80'({valid_o, done_o, busy_o, last_o, col_o, row_o, a_o, b_o}), 80'(0));
        repeat (5) begin
            @(negedge clk_i);
            chk("midframe_reset_no_done", 80'({done_o, valid_o, busy_o}), 80'(0));
        end

        // Zone index 3 does not exist; banks were zeroed by reset so every beat carries a=b=0.
        cfg_wr(2'd3, 16'hDEAD, 16'hBEEF, 16'd0);
        for (int i = 0; i < 8; i++)
            expv[i] = '{16'(i % 4), 16'(i / 4), 16'h0000, 16'h0000, (i == 7)};
        frame(16'd4, 16'd2, 16'd1, 16'd0, 8, 1'b0, -1, 1'b0, 16'h0000);

        // Center col 0x8000: col0 -> dc^2 = 0x40000000 -> d2=0 (zone2); col1 -> 0x3FFF0001 -> d2=1 (zone0).
        cfg_wr(2'd0, 16'h3C00, 16'h1111, 16'd1);
        cfg_wr(2'd1, 16'h4000, 16'h2222, 16'd4);
        cfg_wr(2'd2, 16'h4200, 16'h3333, 16'h7777);
        expv[0] = '{16'd0, 16'd0, 16'h4200, 16'h3333, 1'b0};
        expv[1] = '{16'd1, 16'd0, 16'h3C00, 16'h1111, 1'b1};
        frame(16'd2, 16'd1, 16'h8000, 16'd0, 2, 1'b0, -1, 1'b0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
